axis_ipv4_filter: RTL and testbench

AXIS_IPV4_FILTER -- requirements
Module: axis_ipv4_filter

---
 rtl/axis_ipv4_filter_if.sv | 16 +
 rtl/axis_ipv4_filter.sv | 162 ++++++++++++++++
 tb/tb_axis_ipv4_filter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_ipv4_filter_if.sv
// axis_if: AXI4-Stream bundle (tdata/tvalid/tready/tlast), shared by the
// ingress and egress ports of axis_ipv4_filter.
//   master : drives tdata, tvalid, tlast; receives tready
//   slave  : receives tdata, tvalid, tlast; drives tready
// Byte i of a beat is tdata[8i+7:8i].
interface axis_if #(
    parameter int DATA_WIDTH = 512
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_ipv4_filter.sv
// axis_ipv4_filter: forwards IPv4 Ethernet frames and discards everything
// else. The decision is taken on beat 0 only (ethertype, IP version and the
// IP total length). Forwarded frames go through a single output register
// slice and are cut at MAX_PKT_BYTES with tlast forced on the last allowed
// beat; the rest of such a frame is swallowed.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   s_axis     : ingress stream (axis_if.slave)
//   m_axis     : egress stream to the DDR writer (axis_if.master)
//   frame_busy : high while a frame is open (state != S_HDR)
//   pass_cnt, drop_cnt, trunc_cnt : 32-bit saturating frame counters,
//                only present when AXIS_IPV4_FILTER_STATS_EN is defined
//
// State | meaning
// ------+--------------------------------------------------------------
// S_HDR | waiting for beat 0 of the next frame
// S_PASS| frame accepted, forwarding beats
// S_DROP| frame rejected or truncated, absorbing beats until input tlast
module axis_ipv4_filter #(
    parameter int DATA_WIDTH    = 512,
    parameter int MAX_PKT_BYTES = 2048
) (
    input  logic   clk,
    input  logic   rst_n,
    axis_if.slave  s_axis,
    axis_if.master m_axis,
    output logic   frame_busy
`ifdef AXIS_IPV4_FILTER_STATS_EN
    ,
    output logic [31:0] pass_cnt,
    output logic [31:0] drop_cnt,
    output logic [31:0] trunc_cnt
`endif
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int N_BEATS    = MAX_PKT_BYTES / BEAT_BYTES;
    localparam int CNT_W      = $clog2(N_BEATS) + 1;
    localparam bit ONE_BEAT   = (N_BEATS == 1);

    localparam logic [15:0]      L_MIN     = 16'd20;
    localparam logic [15:0]      L_MAX     = 16'(MAX_PKT_BYTES - 14);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        beat_cnt;   // beats of the current passed frame already taken
    logic                    m_valid_q;
    logic                    m_last_q;
    logic [DATA_WIDTH-1:0]   m_data_q;

    logic        s_ready;
    logic        s_hs;
    logic [15:0] ip_len;
    logic        hdr_ok;
    logic        at_limit;
    logic        fwd;
    logic        cut;

    assign ip_len = {s_axis.tdata[8*16 +: 8], s_axis.tdata[8*17 +: 8]};

    assign hdr_ok = (s_axis.tdata[8*12 +: 8] == 8'h08) &&
                    (s_axis.tdata[8*13 +: 8] == 8'h00) &&
                    (s_axis.tdata[8*14+4 +: 4] == 4'h4) &&
                    (ip_len >= L_MIN) && (ip_len <= L_MAX);

    // Ready is forced low in reset so nothing is taken while the slice clears.
    assign s_ready = rst_n && ((state == S_DROP) || !m_valid_q || m_axis.tready);
    assign s_hs    = s_axis.tvalid && s_ready;

    // Current input beat is the last one allowed through (1-based beat N).
    assign at_limit = (state == S_HDR) ? ONE_BEAT
                                       : ((beat_cnt + 1'b1) == LAST_BEAT);

    assign fwd = s_hs && (((state == S_HDR) && hdr_ok) || (state == S_PASS));
    assign cut = fwd && at_limit && !s_axis.tlast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_HDR;
            beat_cnt  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            if (m_valid_q && m_axis.tready) begin
                m_valid_q <= 1'b0;
            end

            // s_ready guarantees the slice is free or draining when fwd is set.
            if (fwd) begin
                m_valid_q <= 1'b1;
                m_data_q  <= s_axis.tdata;
                m_last_q  <= s_axis.tlast || at_limit;
            end

            if (s_hs) begin
                case (state)
                    S_HDR: begin
                        beat_cnt <= hdr_ok ? CNT_W'(1) : '0;
                        if (s_axis.tlast) begin
                            state <= S_HDR;
                        end else if (!hdr_ok || cut) begin
                            state <= S_DROP;
                        end else begin
                            state <= S_PASS;
                        end
                    end
                    S_PASS: begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (s_axis.tlast) begin
                            state <= S_HDR;
                        end else if (cut) begin
                            state <= S_DROP;
                        end
                    end
                    S_DROP: begin
                        if (s_axis.tlast) begin
                            state <= S_HDR;
                        end
                    end
                    default: state <= S_HDR;
                endcase
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tlast  = m_last_q;
    assign frame_busy    = (state != S_HDR);

`ifdef AXIS_IPV4_FILTER_STATS_EN
    // A frame is counted as truncated only when beats were actually cut off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_cnt  <= '0;
            drop_cnt  <= '0;
            trunc_cnt <= '0;
        end else begin
            if (s_hs && (state == S_HDR) && hdr_ok && (pass_cnt != '1)) begin
                pass_cnt <= pass_cnt + 1'b1;
            end
            if (s_hs && (state == S_HDR) && !hdr_ok && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (cut && (trunc_cnt != '1)) begin
                trunc_cnt <= trunc_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_ipv4_filter.sv
`timescale 1ns/1ps
module tb_axis_ipv4_filter;

    localparam int DW = 512;
    localparam int MAXB = 2048;
    localparam int NB = MAXB / (DW / 8);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_busy;
`ifdef AXIS_IPV4_FILTER_STATS_EN
    logic [31:0] pass_cnt, drop_cnt, trunc_cnt;
`endif

    axis_if #(.DATA_WIDTH(DW)) s_axis ();
    axis_if #(.DATA_WIDTH(DW)) m_axis ();

    axis_ipv4_filter #(.DATA_WIDTH(DW), .MAX_PKT_BYTES(MAXB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_axis     (s_axis),
        .m_axis     (m_axis),
        .frame_busy (frame_busy)
`ifdef AXIS_IPV4_FILTER_STATS_EN
        ,
        .pass_cnt   (pass_cnt),
        .drop_cnt   (drop_cnt),
        .trunc_cnt  (trunc_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;

    int    n_pass = 0;
    int    n_total = 0;
    int    cyc = 0;
    int    stall_viol = 0;
    bit    toggle_en = 0;
    beat_t out_q[$];
    beat_t exp_q[$];
    int    in_cyc_q[$];

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    // Record both sides at the falling edge; inputs and m_tready only move at posedge+1.
    always @(negedge clk) begin
        if (rst_n && s_axis.tvalid && s_axis.tready) in_cyc_q.push_back(cyc);
        if (m_axis.tvalid && m_axis.tready) out_q.push_back('{m_axis.tdata, m_axis.tlast, cyc});
        if (prev_stall && (m_axis.tvalid !== 1'b1 || m_axis.tdata !== prev_data ||
                           m_axis.tlast !== prev_last)) stall_viol++;
        prev_stall = m_axis.tvalid && !m_axis.tready;
        prev_data  = m_axis.tdata;
        prev_last  = m_axis.tlast;
    end

    function automatic logic [DW-1:0] beat_data(input int tag, input int idx);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = {tag[7:0], idx[7:0], k[7:0], 8'h5A};
        return d;
    endfunction

    function automatic logic [DW-1:0] make_hdr(input int tag, input logic [15:0] eth,
                                               input logic [3:0] ver, input logic [15:0] len);
        logic [DW-1:0] d;
        d = beat_data(tag, 0);
        d[8*12 +: 8] = eth[15:8];
        d[8*13 +: 8] = eth[7:0];
        d[8*14 +: 8] = {ver, 4'h5};
        d[8*16 +: 8] = len[15:8];
        d[8*17 +: 8] = len[7:0];
        return d;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic clear_logs();
        out_q.delete();
        exp_q.delete();
        in_cyc_q.delete();
        stall_viol = 0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last, output int waits);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = d;
        s_axis.tlast  = last;
        waits = 0;
        forever begin
            @(negedge clk);
            if (s_axis.tready === 1'b1) break;
            waits++;
            if (waits > 200) begin
                n_total++;
                $display("FAIL send_timeout: tready stayed %b, required 1 within 200 cycles", s_axis.tready);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int tag, input int n, input logic [DW-1:0] hdr, output int waits);
        int w;
        waits = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(i == 0 ? hdr : beat_data(tag, i), i == n - 1, w);
            waits += w;
        end
    endtask

    // Expected egress beats for an accepted frame of n beats, cut at NB.
    task automatic add_exp(input int tag, input int n, input logic [DW-1:0] hdr);
        for (int i = 0; i < n && i < NB; i++)
            exp_q.push_back('{(i == 0) ? hdr : beat_data(tag, i), (i == n - 1) || (i == NB - 1), 0});
    endtask

    task automatic test_reset();
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = make_hdr(1, 16'h0800, 4'h4, 16'd100);
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;
        rst_n = 1'b0;
        tick(3);
        @(negedge clk);
        n_total++; if (m_axis.tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_axis.tvalid); else n_pass++;
        n_total++; if (m_axis.tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", m_axis.tlast); else n_pass++;
        n_total++; if (m_axis.tdata !== '0) $display("FAIL reset_tdata: got %h want 0", m_axis.tdata); else n_pass++;
        n_total++; if (frame_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", frame_busy); else n_pass++;
        n_total++; if (s_axis.tready !== 1'b0) $display("FAIL reset_tready: got %b want 0", s_axis.tready); else n_pass++;
`ifdef AXIS_IPV4_FILTER_STATS_EN
        n_total++; if ({pass_cnt, drop_cnt, trunc_cnt} !== 96'd0) $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", pass_cnt, drop_cnt, trunc_cnt); else n_pass++;
`endif
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_valid_frame();
        logic [DW-1:0] h;
        int w;
        clear_logs();
        m_axis.tready = 1'b1;
        h = make_hdr(2, 16'h0800, 4'h4, 16'd150);
        add_exp(2, 3, h);
        send_frame(2, 3, h, w);
        idle();
        tick(4);
        n_total++;
        if (out_q.size() != 3 || in_cyc_q.size() != 3)
            $display("FAIL valid_count: got %0d out/%0d in beats want 3/3", out_q.size(), in_cyc_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (out_q[i].data !== exp_q[i].data) $display("FAIL valid_data[%0d]: got %h want %h", i, out_q[i].data, exp_q[i].data); else n_pass++;
                n_total++;
                if (out_q[i].last !== exp_q[i].last) $display("FAIL valid_last[%0d]: got %b want %b", i, out_q[i].last, exp_q[i].last); else n_pass++;
                n_total++;
                if (out_q[i].cyc != in_cyc_q[i] + 1) $display("FAIL valid_latency[%0d]: got %0d want 1", i, out_q[i].cyc - in_cyc_q[i]); else n_pass++;
            end
        end
        n_total++; if (frame_busy !== 1'b0) $display("FAIL valid_busy_end: got %b want 0", frame_busy); else n_pass++;
    endtask

    task automatic test_wrong_ethertype();
        int w;
`ifdef AXIS_IPV4_FILTER_STATS_EN
        logic [31:0] d0;
        d0 = drop_cnt;
`endif
        clear_logs();
        m_axis.tready = 1'b1;
        send_frame(3, 4, make_hdr(3, 16'h86DD, 4'h4, 16'd150), w);
        idle();
        tick(4);
        n_total++; if (out_q.size() != 0) $display("FAIL ethertype_out: got %0d beats want 0", out_q.size()); else n_pass++;
        n_total++; if (w != 0) $display("FAIL ethertype_ready: got %0d stall cycles want 0", w); else n_pass++;
        n_total++; if (in_cyc_q.size() != 4) $display("FAIL ethertype_absorb: got %0d beats taken want 4", in_cyc_q.size()); else n_pass++;
`ifdef AXIS_IPV4_FILTER_STATS_EN
        n_total++; if (drop_cnt - d0 !== 32'd1) $display("FAIL ethertype_dropcnt: got +%0d want +1", drop_cnt - d0); else n_pass++;
`endif
    endtask

    task automatic test_boundaries();
        logic [DW-1:0] h;
        int w;
        clear_logs();
        m_axis.tready = 1'b1;
        send_frame(4, 2, make_hdr(4, 16'h0800, 4'h4, 16'd2035), w);
        h = make_hdr(5, 16'h0800, 4'h4, 16'd2034);
        add_exp(5, 2, h);
        send_frame(5, 2, h, w);
        send_frame(6, 2, make_hdr(6, 16'h0800, 4'h4, 16'd19), w);
        h = make_hdr(7, 16'h0800, 4'h4, 16'd20);
        add_exp(7, 2, h);
        send_frame(7, 2, h, w);
        send_frame(8, 2, make_hdr(8, 16'h0800, 4'h6, 16'd100), w);
        send_frame(9, 2, make_hdr(9, 16'h0801, 4'h4, 16'd100), w);
        idle();
        tick(4);
        n_total++;
        if (out_q.size() != exp_q.size()) $display("FAIL bound_count: got %0d beats want %0d", out_q.size(), exp_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < exp_q.size(); i++) begin
                n_total++;
                if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last)
                    $display("FAIL bound_beat[%0d]: got %h/%b want %h/%b", i, out_q[i].data, out_q[i].last, exp_q[i].data, exp_q[i].last);
                else n_pass++;
            end
        end
    endtask

    task automatic test_truncation();
        logic [DW-1:0] h;
        int w;
        int nlast;
`ifdef AXIS_IPV4_FILTER_STATS_EN
        logic [31:0] t0;
        t0 = trunc_cnt;
`endif
        clear_logs();
        m_axis.tready = 1'b1;
        h = make_hdr(20, 16'h0800, 4'h4, 16'd1500);
        add_exp(20, 40, h);
        send_frame(20, 40, h, w);
        idle();
        tick(4);
        n_total++; if (in_cyc_q.size() != 40) $display("FAIL trunc_absorb: got %0d beats taken want 40", in_cyc_q.size()); else n_pass++;
        n_total++; if (w != 0) $display("FAIL trunc_ready: got %0d stall cycles want 0", w); else n_pass++;
        n_total++; if (frame_busy !== 1'b0) $display("FAIL trunc_busy: got %b want 0", frame_busy); else n_pass++;
`ifdef AXIS_IPV4_FILTER_STATS_EN
        n_total++; if (trunc_cnt - t0 !== 32'd1) $display("FAIL trunc_cnt: got +%0d want +1", trunc_cnt - t0); else n_pass++;
`endif
        // Exactly NB beats followed by a 1-beat frame: tlast on NB, nothing dropped after.
        h = make_hdr(21, 16'h0800, 4'h4, 16'd2000);
        add_exp(21, NB, h);
        send_frame(21, NB, h, w);
        h = make_hdr(22, 16'h0800, 4'h4, 16'd60);
        add_exp(22, 1, h);
        send_frame(22, 1, h, w);
        idle();
        tick(4);
        n_total++;
        if (out_q.size() != exp_q.size()) $display("FAIL trunc_count: got %0d beats want %0d", out_q.size(), exp_q.size());
        else begin
            n_pass++;
            nlast = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last) nlast++;
            end
            n_total++;
            if (nlast != 0) $display("FAIL trunc_beats: got %0d wrong beats want 0", nlast); else n_pass++;
            n_total++;
            if (out_q[NB-1].last !== 1'b1) $display("FAIL trunc_last32: got %b want 1", out_q[NB-1].last); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] h;
        int w;
        int wt;
        clear_logs();
        m_axis.tready = 1'b1;
        wt = 0;
        h = make_hdr(40, 16'h0800, 4'h4, 16'd46);
        add_exp(40, 1, h);
        send_frame(40, 1, h, w); wt += w;
        n_total++; if (frame_busy !== 1'b0) $display("FAIL b2b_single_busy: got %b want 0", frame_busy); else n_pass++;
        h = make_hdr(41, 16'h0800, 4'h4, 16'd100);
        add_exp(41, 2, h);
        send_frame(41, 2, h, w); wt += w;
        send_frame(42, 1, make_hdr(42, 16'h0806, 4'h4, 16'd100), w); wt += w;
        h = make_hdr(43, 16'h0800, 4'h4, 16'd200);
        add_exp(43, 2, h);
        send_frame(43, 2, h, w); wt += w;
        idle();
        tick(4);
        n_total++; if (wt != 0) $display("FAIL b2b_gaps: got %0d stall cycles want 0", wt); else n_pass++;

        // Same traffic pattern under 1010 backpressure.
        m_axis.tready = 1'b1;
        toggle_en = 1'b1;
        fork
            begin
                while (toggle_en) begin
                    @(posedge clk); #1;
                    m_axis.tready = ~m_axis.tready;
                end
            end
        join_none
        h = make_hdr(50, 16'h0800, 4'h4, 16'd46);
        add_exp(50, 1, h);
        send_frame(50, 1, h, w);
        h = make_hdr(51, 16'h0800, 4'h4, 16'd300);
        add_exp(51, 2, h);
        send_frame(51, 2, h, w);
        send_frame(52, 1, make_hdr(52, 16'h0800, 4'h5, 16'd100), w);
        h = make_hdr(53, 16'h0800, 4'h4, 16'd400);
        add_exp(53, 2, h);
        send_frame(53, 2, h, w);
        h = make_hdr(54, 16'h0800, 4'h4, 16'd64);
        add_exp(54, 1, h);
        send_frame(54, 1, h, w);
        idle();
        tick(20);
        toggle_en = 1'b0;
        tick(2);
        m_axis.tready = 1'b1;
        tick(3);
        n_total++;
        if (out_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d beats want %0d", out_q.size(), exp_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < exp_q.size(); i++) begin
                n_total++;
                if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last)
                    $display("FAIL b2b_beat[%0d]: got %h/%b want %h/%b", i, out_q[i].data, out_q[i].last, exp_q[i].data, exp_q[i].last);
                else n_pass++;
            end
        end
        n_total++; if (stall_viol != 0) $display("FAIL b2b_stable: got %0d changes while stalled want 0", stall_viol); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] h;
        int w;
        int nl;
        clear_logs();
        m_axis.tready = 1'b1;
        h = make_hdr(60, 16'h0800, 4'h4, 16'd300);
        send_beat(h, 1'b0, w);
        send_beat(beat_data(60, 1), 1'b0, w);
        s_axis.tdata = beat_data(60, 2);
        s_axis.tvalid = 1'b1;
        s_axis.tlast = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_total++; if (s_axis.tready !== 1'b0) $display("FAIL rstmid_tready: got %b want 0", s_axis.tready); else n_pass++;
        @(negedge clk);
        n_total++; if (m_axis.tvalid !== 1'b0) $display("FAIL rstmid_tvalid: got %b want 0", m_axis.tvalid); else n_pass++;
        n_total++; if (frame_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", frame_busy); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        tick(2);
        nl = 0;
        foreach (out_q[i]) if (out_q[i].last !== 1'b0) nl++;
        n_total++;
        if (out_q.size() != 2 || nl != 0) $display("FAIL rstmid_partial: got %0d beats/%0d tlast want 2/0", out_q.size(), nl); else n_pass++;
        clear_logs();
        h = make_hdr(61, 16'h0800, 4'h4, 16'd120);
        add_exp(61, 2, h);
        send_frame(61, 2, h, w);
        idle();
        tick(4);
        n_total++;
        if (out_q.size() != 2) $display("FAIL rstmid_next_count: got %0d beats want 2", out_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 2; i++) begin
                n_total++;
                if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last)
                    $display("FAIL rstmid_next[%0d]: got %h/%b want %h/%b", i, out_q[i].data, out_q[i].last, exp_q[i].data, exp_q[i].last);
                else n_pass++;
            end
        end
    endtask

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b0;
        #1;
        test_reset();
        test_valid_frame();
        test_wrong_ethertype();
        test_boundaries();
        test_truncation();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
